// File: rtl/adder32_share_ctrl.sv
// Round-robin sequencer sharing one 16-bit ripple adder among NREQ clients.
// Each 32-bit add runs as a low pass then a high pass with registered carry.
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module adder32_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*32-1:0] a_in,
  input  logic [NREQ*32-1:0] b_in,
  input  logic [NREQ-1:0]  cin_in,
  output logic [NREQ-1:0]  ack,
  output logic [31:0]      sum_out,
  output logic             cout_out,
  output logic [IDW-1:0]   id_out,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE, LOW, HIGH, DONE
  } state_t;

  state_t         state, nstate;
  logic [IDW-1:0] last, gid;
  logic [31:0]    a_cap, b_cap;
  logic           cin_cap;
  logic [15:0]    lo_sum;
  logic           c16;

  logic           found;
  logic [IDW-1:0] winner;
  logic [31:0]    a_sel, b_sel;
  logic           c_sel;
  int             idx;

  logic [15:0]    add_a, add_b, add_s;
  logic           add_ci, add_co;

  // Scan from last+1 upward with wrap; first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    a_sel  = '0;
    b_sel  = '0;
    c_sel  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
        a_sel  = a_in[32*idx +: 32];
        b_sel  = b_in[32*idx +: 32];
        c_sel  = cin_in[idx];
      end
    end
  end

  always_comb begin
    add_a  = a_cap[15:0];
    add_b  = b_cap[15:0];
    add_ci = cin_cap;
    if (state == HIGH) begin
      add_a  = a_cap[31:16];
      add_b  = b_cap[31:16];
      add_ci = c16;
    end
  end

  adder16 u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (found) nstate = LOW;
      LOW:  nstate = HIGH;
      HIGH: nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Result registers load on the HIGH edge and hold until the next add.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= IDW'(NREQ - 1);
      gid      <= '0;
      a_cap    <= '0;
      b_cap    <= '0;
      cin_cap  <= 1'b0;
      lo_sum   <= '0;
      c16      <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      id_out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            a_cap   <= a_sel;
            b_cap   <= b_sel;
            cin_cap <= c_sel;
            gid     <= winner;
            last    <= winner;
          end
        end
        LOW: begin
          lo_sum <= add_s;
          c16    <= add_co;
        end
        HIGH: begin
          sum_out  <= {add_s, lo_sum};
          cout_out <= add_co;
          id_out   <= gid;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack  = '0;
    busy = (state != IDLE);
    if (state == DONE) ack[gid] = 1'b1;
  end
endmodule

// File: tb/tb_adder32_share_ctrl.sv
// Directed bench for adder32_share_ctrl: arithmetic, latency,
// round-robin order, reset abort and request drop.
module tb_adder32_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] a_in, b_in;
  logic [NREQ-1:0]   cin_in;
  logic [NREQ-1:0]   ack;
  logic [31:0]       sum_out;
  logic              cout_out;
  logic [IDW-1:0]    id_out;
  logic              busy;

  int checks = 0;
  int failures = 0;

  adder32_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .ack      (ack),
    .sum_out  (sum_out),
    .cout_out (cout_out),
    .id_out   (id_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
    a_in[32*i +: 32] = a;
    b_in[32*i +: 32] = b;
    cin_in[i]        = c;
  endtask

  // Returns the negedge count at which ack was first seen, 0 on timeout.
  task automatic wait_ack(input int maxc, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= maxc && !seen; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000) begin
      failures++; $display("FAIL rst_ack got=%b exp=0000", ack);
    end
    checks++;
    if (sum_out !== 32'h0) begin
      failures++; $display("FAIL rst_sum got=%h exp=0", sum_out);
    end
    checks++;
    if (cout_out !== 1'b0) begin
      failures++; $display("FAIL rst_cout got=%b exp=0", cout_out);
    end
    checks++;
    if (id_out !== 2'd0) begin
      failures++; $display("FAIL rst_id got=%0d exp=0", id_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single();
    int n;
    @(posedge clk); #1;
    set_op(0, 32'h0000FFFF, 32'h00000001, 1'b0);
    req = 4'b0001;
    wait_ack(10, n);
    req = 4'b0000;
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL single_lat got=%0d exp=4", n);
    end
    checks++;
    if (ack !== 4'b0001) begin
      failures++; $display("FAIL single_ack got=%b exp=0001", ack);
    end
    checks++;
    if (sum_out !== 32'h00010000 || cout_out !== 1'b0) begin
      failures++;
      $display("FAIL single_sum got=%b_%h exp=0_00010000", cout_out, sum_out);
    end
    checks++;
    if (id_out !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_id got=%0d busy=%b exp=0 busy=1", id_out, busy);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000 || sum_out !== 32'h00010000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_hold got ack=%b sum=%h busy=%b exp 0000/00010000/0",
               ack, sum_out, busy);
    end
  endtask

  task automatic test_overflow();
    int n;
    @(posedge clk); #1;
    set_op(2, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    req = 4'b0100;
    wait_ack(10, n);
    req = 4'b0000;
    checks++;
    if (n != 4 || ack !== 4'b0100) begin
      failures++; $display("FAIL ovf1_ack got n=%0d ack=%b exp 4/0100", n, ack);
    end
    checks++;
    if (sum_out !== 32'h0 || cout_out !== 1'b1 || id_out !== 2'd2) begin
      failures++;
      $display("FAIL ovf1_sum got=%b_%h id=%0d exp=1_00000000 id=2",
               cout_out, sum_out, id_out);
    end
    @(posedge clk); #1;
    set_op(2, 32'h80000000, 32'h80000000, 1'b0);
    req = 4'b0100;
    wait_ack(10, n);
    req = 4'b0000;
    checks++;
    if (n != 4 || sum_out !== 32'h0 || cout_out !== 1'b1) begin
      failures++;
      $display("FAIL ovf2_sum got n=%0d %b_%h exp 4 1_00000000", n, cout_out, sum_out);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [31:0] av [NREQ];
    int exp_id [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 32'h10000000 * i + i;
      set_op(i, av[i], 32'h1, 1'b0);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(10, n);
      checks++;
      if (n != 4) begin
        failures++; $display("FAIL rr_gap%0d got=%0d exp=4", k, n);
      end
      checks++;
      if (id_out !== IDW'(exp_id[k]) || ack !== (4'b0001 << exp_id[k])) begin
        failures++;
        $display("FAIL rr_id%0d got id=%0d ack=%b exp id=%0d", k, id_out, ack, exp_id[k]);
      end
      checks++;
      if (sum_out !== av[exp_id[k]] + 32'h1 || cout_out !== 1'b0) begin
        failures++;
        $display("FAIL rr_sum%0d got=%h exp=%h", k, sum_out, av[exp_id[k]] + 32'h1);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    int n;
    int exp_id [3] = '{3, 0, 3};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h100 * i, 32'h5, 1'b0);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      wait_ack(10, n);
      req = 4'b1001;
      checks++;
      if (n == 0 || id_out !== IDW'(exp_id[k])) begin
        failures++;
        $display("FAIL wrap%0d got id=%0d n=%0d exp id=%0d", k, id_out, n, exp_id[k]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int n;
    @(posedge clk); #1;
    set_op(1, 32'h00ABCDEF, 32'h00001111, 1'b1);
    req = 4'b0010;
    wait_ack(3, n);
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL mid_early_ack got n=%0d exp=0", n);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0 || sum_out !== 32'h0 || cout_out !== 1'b0 ||
        id_out !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got ack=%b sum=%h c=%b id=%0d busy=%b exp all 0",
               ack, sum_out, cout_out, id_out, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      failures++; $display("FAIL rst_vs_req got busy=%b ack=%b exp 0/0000", busy, ack);
    end
    rst = 1'b0;
    wait_ack(10, n);
    req = 4'b0000;
    checks++;
    if (n != 3 || ack !== 4'b0010) begin
      failures++; $display("FAIL mid_retry got n=%0d ack=%b exp 3/0010", n, ack);
    end
    checks++;
    if (sum_out !== 32'h00ABDF01 || cout_out !== 1'b0 || id_out !== 2'd1) begin
      failures++;
      $display("FAIL mid_sum got=%b_%h id=%0d exp=0_00abdf01 id=1",
               cout_out, sum_out, id_out);
    end
  endtask

  task automatic test_drop();
    int n;
    @(posedge clk); #1;
    set_op(1, 32'h12345678, 32'h11111111, 1'b0);
    req = 4'b0010;
    @(posedge clk); #1;
    req = 4'b0000;
    set_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_ack(10, n);
    checks++;
    if (n != 3 || ack !== 4'b0010) begin
      failures++; $display("FAIL drop_ack got n=%0d ack=%b exp 3/0010", n, ack);
    end
    checks++;
    if (sum_out !== 32'h23456789 || cout_out !== 1'b0) begin
      failures++; $display("FAIL drop_sum got=%b_%h exp=0_23456789", cout_out, sum_out);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      failures++; $display("FAIL drop_idle got busy=%b ack=%b exp 0/0000", busy, ack);
    end
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    cin_in = '0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
